// File: rtl/mem_fill_engine_if.sv
// rtl/mem_fill_engine_if.sv - control and RAM write port bundle for mem_fill_engine
interface mem_fill_engine_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              start;
   logic [1:0]        mode;
   logic [DATA_W-1:0] fill_value;
   logic              hold;
   logic              abort;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic              busy;
   logic              done;

   modport master (
      output start, mode, fill_value, hold, abort,
      input  address, data, wren, busy, done
   );

   modport slave (
      input  start, mode, fill_value, hold, abort,
      output address, data, wren, busy, done
   );
endinterface

// File: rtl/mem_fill_engine.sv
// rtl/mem_fill_engine.sv - sweeps a single-port RAM writing one patterned word per cycle
module mem_fill_engine #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   mem_fill_engine_if.slave fill_if
);
   if (DEPTH < 2 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_depth_check
      $error("mem_fill_engine: DEPTH out of range for ADDR_W");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic [DATA_W-1:0] pattern;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         fill_q  <= fill_d;
      end
   end

   // Width casts zero-extend or truncate the address-domain values into DATA_W.
   always_comb begin
      pattern = '0;
      case (mode_q)
         2'd0:    pattern = DATA_W'(cnt_q);
         2'd1:    pattern = DATA_W'(LAST_ADDR - cnt_q);
         2'd2:    pattern = fill_q;
         default: pattern = DATA_W'(cnt_q) ^ fill_q;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      mode_d          = mode_q;
      fill_d          = fill_q;
      fill_if.address = '0;
      fill_if.data    = '0;
      fill_if.wren    = 1'b0;
      fill_if.busy    = 1'b0;
      fill_if.done    = 1'b0;

      case (state_q)
         IDLE: begin
            if (fill_if.start) begin
               mode_d  = fill_if.mode;
               fill_d  = fill_if.fill_value;
               cnt_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            fill_if.busy    = 1'b1;
            fill_if.wren    = ~fill_if.hold & ~fill_if.abort;
            fill_if.address = cnt_q;
            fill_if.data    = pattern;
            // Abort outranks hold; the last-address compare stops the sweep before any wrap.
            if (fill_if.abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!fill_if.hold) begin
               if (cnt_q == LAST_ADDR) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            fill_if.done = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mem_fill_engine.sv
// tb/tb_mem_fill_engine.sv - randomized self-checking bench for mem_fill_engine
module tb_mem_fill_engine;
   logic        clk;
   logic        rst_n;
   int          sel;
   logic        start_r;
   logic [1:0]  mode_r;
   logic [15:0] fill_r;
   logic        hold_r;
   logic        abort_r;
   logic [26:0] obs;
   int          n_total;
   int          n_pass;

   mem_fill_engine_if #(.ADDR_W(8), .DATA_W(8))  ifa ();
   mem_fill_engine_if #(.ADDR_W(8), .DATA_W(8))  ifb ();
   mem_fill_engine_if #(.ADDR_W(8), .DATA_W(16)) ifc ();

   mem_fill_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut_a (
      .clk_i(clk), .reset_n_i(rst_n), .fill_if(ifa));
   mem_fill_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(16)) dut_b (
      .clk_i(clk), .reset_n_i(rst_n), .fill_if(ifb));
   mem_fill_engine #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut_c (
      .clk_i(clk), .reset_n_i(rst_n), .fill_if(ifc));

   assign ifa.start      = start_r & (sel == 0);
   assign ifb.start      = start_r & (sel == 1);
   assign ifc.start      = start_r & (sel == 2);
   assign ifa.mode       = mode_r;
   assign ifb.mode       = mode_r;
   assign ifc.mode       = mode_r;
   assign ifa.fill_value = fill_r[7:0];
   assign ifb.fill_value = fill_r[7:0];
   assign ifc.fill_value = fill_r;
   assign ifa.hold       = hold_r;
   assign ifb.hold       = hold_r;
   assign ifc.hold       = hold_r;
   assign ifa.abort      = abort_r;
   assign ifb.abort      = abort_r;
   assign ifc.abort      = abort_r;

   always_comb begin
      obs = '0;
      case (sel)
         0:       obs = {ifa.busy, ifa.wren, ifa.done, ifa.address, 8'h00, ifa.data};
         1:       obs = {ifb.busy, ifb.wren, ifb.done, ifb.address, 8'h00, ifb.data};
         default: obs = {ifc.busy, ifc.wren, ifc.done, ifc.address, ifc.data};
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] model_data(int m, int f, int addr, int depth, int dw);
      int v;
      case (m)
         0:       v = addr;
         1:       v = depth - 1 - addr;
         2:       v = f;
         default: v = addr ^ f;
      endcase
      return 16'(v & ((1 << dw) - 1));
   endfunction

   // Entry at a negedge with the selected DUT idle; exit in the idle cycle after done.
   task automatic run_sweep(input int m, input int f, input int hold_pct,
                            input int hold_at, input int abort_at, input bit keep_start);
      int          depth;
      int          dw;
      int          a;
      int          cyc;
      int          held_n;
      bit          hb;
      bit          ab;
      logic [26:0] e;
      logic [26:0] mk;
      depth  = (sel == 1) ? 16 : 256;
      dw     = (sel == 2) ? 16 : 8;
      a      = 0;
      cyc    = 0;
      held_n = 0;
      mode_r = 2'(m); fill_r = 16'(f); start_r = 1'b1; hold_r = 1'b0; abort_r = 1'b0;
      #1;
      n_total++;
      if (obs !== 27'h0) $display("FAIL idle_entry: got %h expected %h", obs, 27'h0);
      else n_pass++;
      @(negedge clk);
      while (a < depth && cyc < 4 * depth + 16) begin
         if (!keep_start) start_r = 1'($urandom_range(1));
         mode_r = 2'($urandom_range(3));
         fill_r = 16'($urandom);
         ab = (a == abort_at);
         if (a == hold_at && held_n < 3) begin
            hb = 1'b1;
            held_n++;
         end else begin
            hb = ($urandom_range(99) < hold_pct);
         end
         if (ab) start_r = 1'b0;
         hold_r  = hb;
         abort_r = ab;
         #1;
         e  = {1'b1, ~(hb | ab), 1'b0, 8'(a), model_data(m, f, a, depth, dw)};
         mk = (hb | ab) ? {11'h7FF, 16'h0000} : '1;
         n_total++;
         if ((obs & mk) !== (e & mk))
            $display("FAIL sweep addr=%0d hold=%0d abort=%0d: got %h expected %h mask %h",
                     a, hb, ab, obs, e, mk);
         else n_pass++;
         if (ab) begin
            @(negedge clk);
            abort_r = 1'b0; hold_r = 1'b0; start_r = 1'b0;
            repeat (3) begin
               #1;
               n_total++;
               if (obs !== 27'h0) $display("FAIL abort_idle: got %h expected %h", obs, 27'h0);
               else n_pass++;
               @(negedge clk);
            end
            return;
         end
         if (!hb) a++;
         cyc++;
         @(negedge clk);
      end
      n_total++;
      if (a !== depth) $display("FAIL sweep_timeout: got %0d writes expected %0d", a, depth);
      else n_pass++;
      hold_r = 1'b0; abort_r = 1'b0;
      if (!keep_start) start_r = 1'($urandom_range(1));
      #1;
      e = {3'b001, 24'h0};
      n_total++;
      if (obs !== e) $display("FAIL done_pulse: got %h expected %h", obs, e);
      else n_pass++;
      @(negedge clk);
      if (!keep_start) start_r = 1'b0;
      #1;
      n_total++;
      if (obs !== 27'h0) $display("FAIL idle_after_done: got %h expected %h", obs, 27'h0);
      else n_pass++;
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_total++;
         if (obs !== 27'h0) $display("FAIL reset_state dut%0d: got %h expected %h", s, obs, 27'h0);
         else n_pass++;
      end
      sel = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_total++;
      if (obs !== 27'h0) $display("FAIL post_reset_idle: got %h expected %h", obs, 27'h0);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_identity();
      sel = 0;
      run_sweep(0, 0, 0, -1, -1, 1'b0);
   endtask

   task automatic test_hold();
      sel = 1;
      run_sweep(2, 'hA5, 0, 10, -1, 1'b0);
      @(negedge clk);
      run_sweep(3, int'($urandom_range(255)), 30, -1, -1, 1'b0);
   endtask

   task automatic test_abort();
      sel = 0;
      @(negedge clk);
      run_sweep(0, 0, 0, -1, 100, 1'b0);
      run_sweep(0, 0, 10, -1, -1, 1'b0);
   endtask

   task automatic test_latched_operands();
      sel = 0;
      @(negedge clk);
      run_sweep(1, int'($urandom_range(255)), 20, -1, -1, 1'b0);
      @(negedge clk);
      run_sweep(3, 'hFF, 20, -1, -1, 1'b0);
   endtask

   task automatic test_async_reset();
      sel = 0;
      @(negedge clk);
      mode_r = 2'd0; start_r = 1'b1; hold_r = 1'b0; abort_r = 1'b0;
      @(negedge clk);
      start_r = 1'b0;
      repeat (50) @(negedge clk);
      #1;
      n_total++;
      if (obs[26:16] !== {3'b110, 8'd50})
         $display("FAIL pre_reset_addr: got %h expected %h", obs[26:16], {3'b110, 8'd50});
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (obs !== 27'h0) $display("FAIL async_reset: got %h expected %h", obs, 27'h0);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_sweep(0, 0, 0, -1, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      sel = 1;
      @(negedge clk);
      run_sweep(int'($urandom_range(3)), int'($urandom_range(255)), 0, -1, -1, 1'b1);
      run_sweep(int'($urandom_range(3)), int'($urandom_range(255)), 0, -1, -1, 1'b1);
      run_sweep(int'($urandom_range(3)), int'($urandom_range(255)), 0, -1, -1, 1'b0);
      sel = 2;
      @(negedge clk);
      run_sweep(0, int'($urandom_range(65535)), 0, -1, -1, 1'b0);
      @(negedge clk);
      run_sweep(3, int'($urandom_range(65535)), 15, -1, -1, 1'b0);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      sel     = 0;
      rst_n   = 1'b0;
      start_r = 1'b0;
      mode_r  = 2'd0;
      fill_r  = 16'h0;
      hold_r  = 1'b0;
      abort_r = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_identity();
      test_hold();
      test_abort();
      test_latched_operands();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_fill_engine.md
Name: mem_fill_engine

Overview:
Parametrised successor to the S-memory initializer for the RC4 datapath. It sweeps a single-port RAM from address 0 to DEPTH-1 and writes one word per cycle. The word pattern is selectable: identity, descending, constant or XOR-masked. It exposes a write-enable, a hold input for sharing the RAM port with other masters, an abort input, and a start/busy/done handshake. The top-level FSM sits in front of the RAM write mux.

Parameters:
ADDR_W, 8, address width in bits.
DATA_W, 8, data word width in bits.
DEPTH, 256, number of words written. Legal range is 2 to 2^ADDR_W; an out-of-range value is an elaboration error.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request a fill; sampled only in IDLE.
mode  in  2  pattern select; latched when start is accepted.
fill_value  in  DATA_W  constant/mask operand; latched when start is accepted.
hold  in  1  stall: suppress the write and keep the address.
abort  in  1  terminate the fill; return to IDLE without done.
address  out  ADDR_W  RAM write address.
data  out  DATA_W  RAM write data.
wren  out  1  RAM write enable.
busy  out  1  high while in WRITE.
done  out  1  single-cycle pulse after the last write.

Behaviour:
- Reset (reset_n low, any state, including mid-fill):
  - state goes to IDLE.
  - address, data, wren, busy and done all go to 0.
  - Latched mode and fill_value clear to 0.
- States: IDLE, WRITE, DONE. Encode them with one register.
- IDLE:
  - wren=0, busy=0, done=0.
  - If start=1: latch mode and fill_value, set addr counter to 0, go to WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - busy=1.
  - wren = ~hold & ~abort (combinational from state, hold and abort).
  - address = counter.
- Priority in WRITE, highest first:
  1. abort=1: go to IDLE, counter to 0, no write that cycle, no done pulse.
  2. hold=1: counter and state unchanged, wren=0.
  3. Write occurs and counter==DEPTH-1: go to DONE, counter to 0.
  4. Otherwise: counter increments by 1.
- DONE:
  - done=1 for exactly one cycle, busy=0, wren=0.
  - Unconditionally go to IDLE.
  - A start asserted in the DONE cycle is ignored.
- start is ignored in WRITE and DONE. There is no queuing and a re-trigger never restarts the sweep.
- hold and abort are ignored outside WRITE.
- Data, a combinational function of the counter and the latched operands:
  - mode 0, identity: data = counter zero-extended, or truncated to DATA_W.
  - mode 1, descending: data = (DEPTH-1-counter), width-adjusted the same way.
  - mode 2, constant: data = fill_value.
  - mode 3, masked: data = width-adjusted counter XOR fill_value.
- Width rule: whenever DATA_W differs from ADDR_W, truncate to the low bits or zero-extend.
- address and data are don't-care when wren=0. Outside WRITE they drive 0.
- Latency with no hold:
  - start is accepted at edge N.
  - First write (address 0) is in cycle N+1.
  - Last write (address DEPTH-1) is in cycle N+DEPTH.
  - done is high in cycle N+DEPTH+1.
  - Each hold cycle adds exactly one cycle.
- Counter never wraps: the DEPTH-1 check ends the sweep, including when DEPTH=2^ADDR_W.
- abort and hold together: abort wins.

Test Plan:
1. Defaults, mode 0, start for 1 cycle, hold=0 -> 256 writes with data==address from 0x00 to 0xFF, one per cycle; done pulses exactly once, 257 cycles after the start edge; busy falls with it.
2. Mode 2, fill_value=0xA5, DEPTH=16, hold high for 3 cycles while address=10 -> wren=0 for those 3 cycles; address stays 10 and is written exactly once; all 16 words are 0xA5; done comes 3 cycles later than with no hold.
3. Mode 0, abort pulsed while address=100 -> no write at 100; state returns to IDLE; done never asserts; a new start then restarts at address 0.
4. Mode 1 then mode 3 with fill_value=0xFF -> data = 0xFF-address in both modes; change mode and fill_value mid-sweep -> no effect on the data (operands are latched).
5. reset_n low while address=50 -> all outputs 0 asynchronously, without waiting for a clock edge; after release the block is in IDLE and starts cleanly.
6. start held high continuously -> back-to-back sweeps separated by one IDLE cycle; start during WRITE or DONE never restarts a sweep; DATA_W=16, ADDR_W=8 build gives zero-extended identity data.
